// File: rtl/ccip_rd_req_arbiter.sv
// Round-robin sharing of the CCI-P c0 read-request channel among N_REQ engines, with
// per-requester credit limits, tag routing and drain. CCIP_RD_ARB_STATS_EN adds grant_cnt.
module ccip_rd_req_arbiter #(
    parameter int unsigned N_REQ     = 2,
    parameter int unsigned ADDR_W    = 42,
    parameter int unsigned DATA_W    = 512,
    parameter int unsigned MAX_OUTST = 64
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [N_REQ*ADDR_W-1:0] req_addr,
    input  logic [N_REQ*14-1:0]     req_mdata,
    output logic [N_REQ-1:0]        req_ack,
    output logic                    tx_valid,
    output logic [ADDR_W-1:0]       tx_addr,
    output logic [15:0]             tx_mdata,
    input  logic                    tx_almfull,
    input  logic                    rx_valid,
    input  logic [15:0]             rx_mdata,
    input  logic [DATA_W-1:0]       rx_data,
    output logic [N_REQ-1:0]        rsp_valid,
    output logic [13:0]             rsp_mdata,
    output logic [DATA_W-1:0]       rsp_data,
    input  logic                    drain_req,
    output logic                    drained,
`ifdef CCIP_RD_ARB_STATS_EN
    output logic [N_REQ*32-1:0]     grant_cnt,
`endif
    output logic                    tag_err
);

    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_DRAIN = 2'd1;
    localparam logic [1:0] ST_IDLE  = 2'd2;

    localparam logic [7:0] MAX_O    = 8'(MAX_OUTST);
    localparam logic [2:0] N_REQ3   = 3'(N_REQ);
    localparam logic [1:0] LAST_IDX = 2'(N_REQ - 1);

    logic [1:0]              state_q, state_d;
    logic [1:0]              rr_ptr_q, rr_ptr_d;
    logic [N_REQ-1:0][7:0]   outst_q, outst_d;
    logic                    tx_valid_q, tx_valid_d;
    logic [ADDR_W-1:0]       tx_addr_q, tx_addr_d;
    logic [15:0]             tx_mdata_q, tx_mdata_d;
    logic [N_REQ-1:0]        rsp_valid_q, rsp_valid_d;
    logic [13:0]             rsp_mdata_q, rsp_mdata_d;
    logic [DATA_W-1:0]       rsp_data_q, rsp_data_d;
    logic                    tag_err_q, tag_err_d;

    logic                    can_issue;
    logic [3:0]              elig;
    logic [N_REQ-1:0]        grant_vec;
    logic                    grant_any;
    logic [1:0]              grant_idx;
    logic [2:0]              scan_idx;
    logic [1:0]              rx_tag;
    logic                    tag_ok;
    logic                    rx_route;
    logic                    underflow;
    logic                    all_idle;

    assign can_issue = (state_q == ST_RUN) & ~drain_req & ~tx_almfull & ~reset;

    always_comb begin
        elig = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            elig[i] = req_valid[i] & (outst_q[i] < MAX_O) & can_issue;
        end
    end

    // Scan N_REQ slots starting at the pointer; the wrap is mod N_REQ, not mod 4.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        scan_idx  = '0;
        grant_vec = '0;
        for (int unsigned off = 0; off < N_REQ; off++) begin
            scan_idx = {1'b0, rr_ptr_q} + 3'(off);
            if (scan_idx >= N_REQ3) begin
                scan_idx = scan_idx - N_REQ3;
            end
            if (!grant_any && elig[scan_idx[1:0]]) begin
                grant_any = 1'b1;
                grant_idx = scan_idx[1:0];
            end
        end
        for (int unsigned i = 0; i < N_REQ; i++) begin
            grant_vec[i] = grant_any & (grant_idx == 2'(i));
        end
    end

    assign req_ack = grant_vec;

    always_comb begin
        tx_valid_d = grant_any;
        tx_addr_d  = tx_addr_q;
        tx_mdata_d = tx_mdata_q;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (grant_vec[i]) begin
                tx_addr_d  = req_addr[i*ADDR_W +: ADDR_W];
                tx_mdata_d = {2'(i), req_mdata[i*14 +: 14]};
            end
        end
    end

    assign rx_tag   = rx_mdata[15:14];
    assign tag_ok   = ({1'b0, rx_tag} < N_REQ3);
    assign rx_route = rx_valid & tag_ok;

    always_comb begin
        rsp_valid_d = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            rsp_valid_d[i] = rx_route & (rx_tag == 2'(i));
        end
        rsp_mdata_d = rx_route ? rx_mdata[13:0] : rsp_mdata_q;
        rsp_data_d  = rx_route ? rx_data : rsp_data_q;
    end

    // Simultaneous grant and response cancel; a response with nothing outstanding is flagged.
    always_comb begin
        outst_d   = outst_q;
        underflow = 1'b0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (grant_vec[i] && !rsp_valid_d[i]) begin
                outst_d[i] = outst_q[i] + 8'd1;
            end else if (!grant_vec[i] && rsp_valid_d[i]) begin
                if (outst_q[i] == '0) begin
                    underflow = 1'b1;
                end else begin
                    outst_d[i] = outst_q[i] - 8'd1;
                end
            end
        end
        tag_err_d = tag_err_q | (rx_valid & ~tag_ok) | underflow;
    end

    assign all_idle = (outst_q == '0) & ~tx_valid_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN:   if (drain_req) state_d = ST_DRAIN;
            ST_DRAIN: begin
                if (!drain_req) begin
                    state_d = ST_RUN;
                end else if (all_idle) begin
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE:  if (!drain_req) state_d = ST_RUN;
            default:  state_d = ST_RUN;
        endcase
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (grant_any) begin
            rr_ptr_d = (grant_idx == LAST_IDX) ? 2'd0 : grant_idx + 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_RUN;
            rr_ptr_q    <= '0;
            outst_q     <= '0;
            tx_valid_q  <= 1'b0;
            tx_addr_q   <= '0;
            tx_mdata_q  <= '0;
            rsp_valid_q <= '0;
            rsp_mdata_q <= '0;
            rsp_data_q  <= '0;
            tag_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            outst_q     <= outst_d;
            tx_valid_q  <= tx_valid_d;
            tx_addr_q   <= tx_addr_d;
            tx_mdata_q  <= tx_mdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_mdata_q <= rsp_mdata_d;
            rsp_data_q  <= rsp_data_d;
            tag_err_q   <= tag_err_d;
        end
    end

    assign tx_valid  = tx_valid_q;
    assign tx_addr   = tx_addr_q;
    assign tx_mdata  = tx_mdata_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_mdata = rsp_mdata_q;
    assign rsp_data  = rsp_data_q;
    assign drained   = (state_q == ST_IDLE);
    assign tag_err   = tag_err_q;

`ifdef CCIP_RD_ARB_STATS_EN
    logic [N_REQ-1:0][31:0] grant_cnt_q, grant_cnt_d;

    always_comb begin
        grant_cnt_d = grant_cnt_q;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            grant_cnt_d[i] = grant_cnt_q[i] + 32'(grant_vec[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            grant_cnt_q <= '0;
        end else begin
            grant_cnt_q <= grant_cnt_d;
        end
    end

    assign grant_cnt = grant_cnt_q;
`endif

endmodule

// File: tb/tb_ccip_rd_req_arbiter.sv
// Scoreboard bench for ccip_rd_req_arbiter (N_REQ=2, MAX_OUTST=4): a small reference
// model predicts acks, queued tx/rsp expectations are popped one cycle later.
module tb_ccip_rd_req_arbiter;

    localparam int unsigned N  = 2;
    localparam int unsigned AW = 42;
    localparam int unsigned DW = 64;
    localparam int unsigned MO = 4;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [N-1:0]      req_valid = '0;
    logic [N*AW-1:0]   req_addr;
    logic [N*14-1:0]   req_mdata;
    logic [N-1:0]      req_ack;
    logic              tx_valid;
    logic [AW-1:0]     tx_addr;
    logic [15:0]       tx_mdata;
    logic              tx_almfull = 1'b0;
    logic              rx_valid = 1'b0;
    logic [15:0]       rx_mdata = '0;
    logic [DW-1:0]     rx_data = '0;
    logic [N-1:0]      rsp_valid;
    logic [13:0]       rsp_mdata;
    logic [DW-1:0]     rsp_data;
    logic              drain_req = 1'b0;
    logic              drained;
    logic              tag_err;
`ifdef CCIP_RD_ARB_STATS_EN
    logic [N*32-1:0]   grant_cnt;
`endif

    logic [AW-1:0]     ra [N];
    logic [13:0]       rm [N];
    assign req_addr  = {ra[1], ra[0]};
    assign req_mdata = {rm[1], rm[0]};

    ccip_rd_req_arbiter #(
        .N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .MAX_OUTST(MO)
    ) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_addr(req_addr), .req_mdata(req_mdata), .req_ack(req_ack),
        .tx_valid(tx_valid), .tx_addr(tx_addr), .tx_mdata(tx_mdata), .tx_almfull(tx_almfull),
        .rx_valid(rx_valid), .rx_mdata(rx_mdata), .rx_data(rx_data),
        .rsp_valid(rsp_valid), .rsp_mdata(rsp_mdata), .rsp_data(rsp_data),
        .drain_req(drain_req), .drained(drained),
`ifdef CCIP_RD_ARB_STATS_EN
        .grant_cnt(grant_cnt),
`endif
        .tag_err(tag_err)
    );

    always #5 clk = ~clk;

    typedef struct { logic [AW-1:0] addr; logic [15:0] mdata; } tx_exp_t;
    typedef struct { logic [N-1:0] vec; logic [13:0] md; logic [DW-1:0] data; } rsp_exp_t;

    tx_exp_t     txq [$];
    rsp_exp_t    rspq [$];

    int unsigned total = 0;
    int unsigned bad = 0;

    int unsigned m_rr;
    int unsigned m_outst [N];
    int unsigned m_state;
    bit          m_err;
    int unsigned acks [N];
    int unsigned act_acks [N];

    logic [N-1:0] last_ack;
    logic [N-1:0] last_rsp_valid;
    logic [13:0]  last_rsp_mdata;
    logic         last_drained;
    logic         last_tag_err;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        logic [N-1:0] ea;
        logic [N-1:0] rv;
        logic [1:0]   tg;
        bit           tx_now;
        int unsigned  nst;
        tx_exp_t      te;
        rsp_exp_t     re;
        @(negedge clk);
        tx_now = (txq.size() != 0);
        check("tx_valid", {63'd0, tx_valid}, {63'd0, tx_now});
        if (tx_now) begin
            te = txq.pop_front();
            check("tx_addr", 64'(tx_addr), 64'(te.addr));
            check("tx_mdata", 64'(tx_mdata), 64'(te.mdata));
        end
        if (rspq.size() != 0) begin
            re = rspq.pop_front();
            check("rsp_valid", 64'(rsp_valid), 64'(re.vec));
            check("rsp_mdata", 64'(rsp_mdata), 64'(re.md));
            check("rsp_data", rsp_data, re.data);
        end else begin
            check("rsp_valid_idle", 64'(rsp_valid), 64'd0);
        end
        check("drained", {63'd0, drained}, {63'd0, m_state == 2});
        check("tag_err", {63'd0, tag_err}, {63'd0, m_err});

        ea = '0;
        if (m_state == 0 && !drain_req && !tx_almfull) begin
            for (int k = 0; k < N; k++) begin
                int unsigned c;
                c = (m_rr + k) % N;
                if (ea == '0 && req_valid[c] && m_outst[c] < MO) ea[c] = 1'b1;
            end
        end
        check("req_ack", 64'(req_ack), 64'(ea));

        last_ack       = req_ack;
        last_rsp_valid = rsp_valid;
        last_rsp_mdata = rsp_mdata;
        last_drained   = drained;
        last_tag_err   = tag_err;
        for (int i = 0; i < N; i++) if (req_ack[i]) act_acks[i]++;

        nst = m_state;
        case (m_state)
            0: if (drain_req) nst = 1;
            1: begin
                if (!drain_req) nst = 0;
                else if (m_outst[0] == 0 && m_outst[1] == 0 && !tx_now) nst = 2;
            end
            2: if (!drain_req) nst = 0;
            default: nst = 0;
        endcase

        rv = '0;
        tg = rx_mdata[15:14];
        if (rx_valid) begin
            if (tg < N) rv[tg[0]] = 1'b1;
            else m_err = 1'b1;
        end
        for (int i = 0; i < N; i++) begin
            if (ea[i] && !rv[i]) m_outst[i]++;
            else if (!ea[i] && rv[i]) begin
                if (m_outst[i] == 0) m_err = 1'b1;
                else m_outst[i]--;
            end
        end
        if (rv != '0) rspq.push_back('{rv, rx_mdata[13:0], rx_data});
        for (int i = 0; i < N; i++) begin
            if (ea[i]) begin
                txq.push_back('{ra[i], {2'(i), rm[i]}});
                acks[i]++;
            end
        end
        if (ea[0]) m_rr = 1;
        else if (ea[1]) m_rr = 0;
        m_state = nst;

        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (ea[i]) begin
                ra[i] = ra[i] + 1'b1;
                rm[i] = rm[i] + 1'b1;
            end
        end
        rx_valid = 1'b0;
    endtask

    task automatic send_rsp(input logic [15:0] md, input logic [DW-1:0] d);
        rx_valid = 1'b1;
        rx_mdata = md;
        rx_data  = d;
        tick();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        rx_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        m_rr = 0;
        m_state = 0;
        m_err = 1'b0;
        for (int i = 0; i < N; i++) begin
            m_outst[i] = 0;
            acks[i] = 0;
            act_acks[i] = 0;
        end
        txq.delete();
        rspq.delete();
    endtask

    initial begin
        ra[0] = 42'h100;
        ra[1] = 42'h2000_0000;
        rm[0] = 14'h0010;
        rm[1] = 14'h2200;

        // reset state
        do_reset();
        tick();
        check("rst_ack", 64'(last_ack), 64'd0);
        check("rst_drained", {63'd0, last_drained}, 64'd0);

        // alternating grants
        req_valid = 2'b11;
        for (int k = 0; k < 6; k++) begin
            tick();
            check("t1_alt", 64'(last_ack), (k % 2 == 1) ? 64'd2 : 64'd1);
        end
        req_valid = 2'b00;
        for (int k = 0; k < 6; k++) send_rsp({2'(k % 2), 14'(16'h0300 + k)}, 64'(64'hA000 + k));
        repeat (2) tick();

        // credit limit, then same-cycle grant/response at MAX_OUTST-1
        do_reset();
        req_valid = 2'b01;
        repeat (8) tick();
        check("t2_acks", 64'(act_acks[0]), 64'd4);
        send_rsp(16'h0011, 64'h1111);
        check("t2_stall_on_rsp", 64'(last_ack), 64'd0);
        tick();
        check("t2_fifth", 64'(act_acks[0]), 64'd5);
        send_rsp(16'h0012, 64'h2222);
        send_rsp(16'h0013, 64'h3333);
        check("t6_same_cycle", 64'(last_ack), 64'd1);
        tick();
        check("t6_refill", 64'(last_ack), 64'd1);
        tick();
        check("t6_stall", 64'(last_ack), 64'd0);
        req_valid = 2'b00;
        for (int k = 0; k < 4; k++) send_rsp(16'(16'h0020 + k), 64'(k));
        tick();

        // almost-full stall keeps pointer
        do_reset();
        req_valid = 2'b11;
        tick();
        check("t3_first", 64'(last_ack), 64'd1);
        tx_almfull = 1'b1;
        act_acks[0] = 0;
        act_acks[1] = 0;
        repeat (10) tick();
        check("t3_none", 64'(act_acks[0] + act_acks[1]), 64'd0);
        tx_almfull = 1'b0;
        tick();
        check("t3_resume", 64'(last_ack), 64'd2);
        req_valid = 2'b00;
        tick();

        // response routing and bad tag
        do_reset();
        req_valid = 2'b10;
        tick();
        req_valid = 2'b00;
        tick();
        send_rsp(16'h4ABC, 64'hDEAD_BEEF_0123_4567);
        tick();
        check("t4_rsp_valid", 64'(last_rsp_valid), 64'd2);
        check("t4_rsp_mdata", 64'(last_rsp_mdata), 64'h0ABC);
        check("t4_no_err", {63'd0, last_tag_err}, 64'd0);
        send_rsp(16'hC123, 64'h5555);
        tick();
        check("t4_tag_err", {63'd0, last_tag_err}, 64'd1);
        check("t4_dropped", 64'(last_rsp_valid), 64'd0);

        // drain handshake
        do_reset();
        req_valid = 2'b01;
        repeat (3) tick();
        req_valid = 2'b11;
        drain_req = 1'b1;
        act_acks[0] = 0;
        act_acks[1] = 0;
        repeat (3) tick();
        for (int k = 0; k < 3; k++) send_rsp(16'(16'h0040 + k), 64'(64'hB0 + k));
        check("t5_no_acks", 64'(act_acks[0] + act_acks[1]), 64'd0);
        tick();
        check("t5_not_yet", {63'd0, last_drained}, 64'd0);
        tick();
        check("t5_drained", {63'd0, last_drained}, 64'd1);
        drain_req = 1'b0;
        tick();
        tick();
        check("t5_undrained", {63'd0, last_drained}, 64'd0);
        check("t5_resume", 64'(last_ack), 64'd2);
        req_valid = 2'b00;
        tick();

        // late response after reset
        do_reset();
        send_rsp(16'h0001, 64'h77);
        tick();
        check("late_rsp_err", {63'd0, last_tag_err}, 64'd1);

        // random traffic
        do_reset();
        for (int k = 0; k < 1000; k++) begin
            int unsigned t;
            req_valid  = 2'($urandom_range(0, 3));
            tx_almfull = ($urandom_range(0, 7) == 0);
            t = $urandom_range(0, 1);
            if ($urandom_range(0, 1) == 1 && m_outst[t] > 0) begin
                rx_valid = 1'b1;
                rx_mdata = {2'(t), 14'($urandom_range(0, 16383))};
                rx_data  = {$urandom, $urandom};
            end
            tick();
        end
        req_valid  = 2'b00;
        tx_almfull = 1'b0;
`ifdef CCIP_RD_ARB_STATS_EN
        check("grant_cnt0", 64'(grant_cnt[31:0]), 64'(acks[0]));
        check("grant_cnt1", 64'(grant_cnt[63:32]), 64'(acks[1]));
`endif
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
